// File: rtl/booth_pkg.sv
// Shared types and sizing helpers for the Booth MAC sequencer and its accumulator.
package booth_pkg;

  localparam int OP_W_DEF     = 4;
  localparam int N_TERMS_DEF  = 8;
  localparam int MULT_LAT_DEF = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ACCUM = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Bits needed to index v distinct values (clog2(1) = 0).
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/booth_mac_acc.sv
// Signed accumulator for the Booth MAC: sign-extends each product and adds it to the running sum.
// BOOTH_MAC_SAT_EN selects clamping with a sticky sat flag; otherwise the sum wraps modulo 2^ACC_W.
module booth_mac_acc #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              add_i,
  input  logic [PROD_W-1:0] prod_i,
  output logic [ACC_W-1:0]  acc_o,
  output logic              sat_o
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;

`ifdef BOOTH_MAC_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0] sum;
  logic           sat_q;
  logic           sat_d;

  // One guard bit: the two top bits disagree exactly when the true sum leaves ACC_W range.
  always_comb begin
    sum   = {acc_q[ACC_W-1], acc_q} + (ACC_W+1)'($signed(prod_i));
    acc_d = acc_q;
    sat_d = sat_q;
    if (add_i) begin
      if (sum[ACC_W] != sum[ACC_W-1]) begin
        acc_d = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        sat_d = 1'b1;
      end else begin
        acc_d = sum[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign sat_o = sat_q;
`else
  // Wrapping mode only needs the low ACC_W bits of the sum.
  always_comb begin
    acc_d = acc_q;
    if (add_i) begin
      acc_d = acc_q + ACC_W'($signed(prod_i));
    end
  end

  assign sat_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/booth_mac_seq.sv
// Sequencer around an external fixed-latency Booth multiplier: issues operand pairs, accumulates
// N_TERMS products and presents the sum. Optional clamping via BOOTH_MAC_SAT_EN (see booth_mac_acc).
module booth_mac_seq
  import booth_pkg::*;
#(
  parameter int OP_W     = OP_W_DEF,
  parameter int N_TERMS  = N_TERMS_DEF,
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int ACC_W    = 2*OP_W + clog2(N_TERMS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [OP_W-1:0]   a_i,
  input  logic [OP_W-1:0]   b_i,
  output logic              mult_start_o,
  output logic [OP_W-1:0]   mult_a_o,
  output logic [OP_W-1:0]   mult_b_o,
  input  logic [2*OP_W-1:0] mult_result_i,
  output logic              acc_valid_o,
  input  logic              acc_ready_i,
  output logic [ACC_W-1:0]  acc_o,
  output logic              sat_o,
  output logic [2:0]        dbg_state_o
);

  localparam int LAT_W = (clog2(MULT_LAT) > 0) ? clog2(MULT_LAT) : 1;
  localparam int CNT_W = clog2(N_TERMS + 1);

  state_e            state_q;
  logic [LAT_W-1:0]  lat_cnt_q;
  logic [CNT_W-1:0]  term_cnt_q;
  logic              mult_start_q;
  logic              acc_valid_q;
  logic [OP_W-1:0]   mult_a_q;
  logic [OP_W-1:0]   mult_b_q;

  logic accept;
  logic acc_take;

  // Valid/ready: a transfer happens on a posedge where valid and ready are both 1; the sender
  // holds its payload and valid until then. in_ready_o drops during rst/clear_i so no pair is lost.
  assign in_ready_o = (state_q == ST_IDLE) && !rst && !clear_i;
  assign accept     = in_valid_i && in_ready_o;
  assign acc_take   = acc_valid_q && acc_ready_i;

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      state_q      <= ST_IDLE;
      lat_cnt_q    <= '0;
      term_cnt_q   <= '0;
      mult_start_q <= 1'b0;
      acc_valid_q  <= 1'b0;
      mult_a_q     <= '0;
      mult_b_q     <= '0;
    end else begin
      mult_start_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            mult_a_q     <= a_i;
            mult_b_q     <= b_i;
            mult_start_q <= 1'b1;
            state_q      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          lat_cnt_q <= '0;
          state_q   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (lat_cnt_q == LAT_W'(MULT_LAT - 1)) begin
            state_q <= ST_ACCUM;
          end else begin
            lat_cnt_q <= lat_cnt_q + LAT_W'(1);
          end
        end
        ST_ACCUM: begin
          term_cnt_q <= term_cnt_q + CNT_W'(1);
          if (term_cnt_q == CNT_W'(N_TERMS - 1)) begin
            acc_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_DONE: begin
          if (acc_ready_i) begin
            acc_valid_q <= 1'b0;
            term_cnt_q  <= '0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  booth_mac_acc #(
    .PROD_W (2*OP_W),
    .ACC_W  (ACC_W)
  ) u_acc (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (clear_i || acc_take),
    .add_i  (state_q == ST_ACCUM),
    .prod_i (mult_result_i),
    .acc_o  (acc_o),
    .sat_o  (sat_o)
  );

  assign mult_start_o = mult_start_q;
  assign mult_a_o     = mult_a_q;
  assign mult_b_o     = mult_b_q;
  assign acc_valid_o  = acc_valid_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_booth_mac_seq.sv
// Bench for booth_mac_seq: default instance plus an ACC_W=8 instance in lockstep to reach the
// overflow boundary. Multiplier is a behavioural model; sums come from plain integer arithmetic.
`timescale 1ns/1ps
module tb_booth_mac_seq;
  import booth_pkg::*;

  localparam int N_TERMS  = 8;
  localparam int MULT_LAT = 5;
  localparam int ACC_W    = 11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic       acc_ready = 1'b0;
  logic [3:0] a_in = '0;
  logic [3:0] b_in = '0;
  logic [7:0] mult_result = '0;

  logic             in_ready_o, mult_start_o, acc_valid_o, sat_o;
  logic [3:0]       mult_a_o, mult_b_o;
  logic [ACC_W-1:0] acc_o;
  logic [2:0]       dbg_state_o;

  logic       in_ready8, mult_start8, acc_valid8, sat8;
  logic [3:0] mult_a8, mult_b8;
  logic [7:0] acc8;
  logic [2:0] dbg_state8;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_accept = 0;
  int pa[N_TERMS];
  int pb[N_TERMS];
  int mcnt = 0;
  logic [7:0] mpend = '0;

  booth_mac_seq u_dut (
    .clk(clk), .rst(rst), .clear_i(clear), .in_valid_i(in_valid), .in_ready_o(in_ready_o),
    .a_i(a_in), .b_i(b_in), .mult_start_o(mult_start_o), .mult_a_o(mult_a_o), .mult_b_o(mult_b_o),
    .mult_result_i(mult_result), .acc_valid_o(acc_valid_o), .acc_ready_i(acc_ready),
    .acc_o(acc_o), .sat_o(sat_o), .dbg_state_o(dbg_state_o)
  );

  booth_mac_seq #(.ACC_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .clear_i(clear), .in_valid_i(in_valid), .in_ready_o(in_ready8),
    .a_i(a_in), .b_i(b_in), .mult_start_o(mult_start8), .mult_a_o(mult_a8), .mult_b_o(mult_b8),
    .mult_result_i(mult_result), .acc_valid_o(acc_valid8), .acc_ready_i(acc_ready),
    .acc_o(acc8), .sat_o(sat8), .dbg_state_o(dbg_state8)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: garbage until MULT_LAT edges after the start pulse, then the product.
  always @(posedge clk) begin
    if (mult_start_o) begin
      mcnt        <= MULT_LAT;
      mpend       <= 8'($signed(mult_a_o) * $signed(mult_b_o));
      mult_result <= 8'($urandom);
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) mult_result <= mpend;
    end
  end

  // ---------------- reference model ----------------
  function automatic int model_sum(input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += pa[i] * pb[i];
    return s;
  endfunction

  function automatic int model_acc8(input int n, output bit sat);
    int s = 0;
    sat = 1'b0;
`ifdef BOOTH_MAC_SAT_EN
    for (int i = 0; i < n; i++) begin
      s += pa[i] * pb[i];
      if (s > 127) begin s = 127; sat = 1'b1; end
      if (s < -128) begin s = -128; sat = 1'b1; end
    end
`else
    s = model_sum(n) & 255;
    if (s > 127) s -= 256;
`endif
    return s;
  endfunction

  function automatic int rand_op();
    int v = int'($urandom_range(0, 15));
    return (v > 7) ? v - 16 : v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_pair(input int a, input int b);
    int n = 0;
    in_valid = 1'b1;
    a_in = a[3:0];
    b_in = b[3:0];
    while (!in_ready_o && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (!in_ready_o) begin
      errors++;
      $display("FAIL accept_timeout: in_ready_o=%0b required 1", in_ready_o);
    end
    last_accept = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_terms(input int n, output int first_accept);
    first_accept = 0;
    for (int i = 0; i < n; i++) begin
      send_pair(pa[i], pb[i]);
      if (i == 0) first_accept = last_accept;
    end
  endtask

  task automatic wait_done(output bit ok, output int at);
    int n = 0;
    while (!acc_valid_o && n < 200) begin @(negedge clk); n++; end
    ok = acc_valid_o;
    at = cyc;
  endtask

  task automatic take_result();
    acc_ready = 1'b1;
    @(negedge clk);
    acc_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready_o !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b required 0", in_ready_o); end
    checks++;
    if ({mult_start_o, acc_valid_o, sat_o} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: start/valid/sat=%b required 000", {mult_start_o, acc_valid_o, sat_o});
    end
    checks++;
    if (acc_o !== '0 || mult_a_o !== '0 || mult_b_o !== '0) begin
      errors++; $display("FAIL reset_data: acc=%0d a=%0d b=%0d required 0", acc_o, mult_a_o, mult_b_o);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready_o !== 1'b1 || dbg_state_o !== 3'(ST_IDLE)) begin
      errors++; $display("FAIL reset_release: in_ready=%0b state=%0d required 1/%0d", in_ready_o, dbg_state_o, ST_IDLE);
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok;
    int t0, t1, exp8, got8;
    bit es;
    for (int i = 0; i < N_TERMS; i++) begin pa[i] = 3; pb[i] = 2; end
    send_terms(N_TERMS, t0);
    wait_done(ok, t1);
    checks++;
    if (!ok || t1 - t0 != 64) begin
      errors++; $display("FAIL basic_latency: valid=%0b cycles=%0d required 64", ok, t1 - t0);
    end
    checks++;
    if (int'($signed(acc_o)) !== 48) begin errors++; $display("FAIL basic_sum: got %0d required 48", $signed(acc_o)); end
    exp8 = model_acc8(N_TERMS, es);
    got8 = int'($signed(acc8));
    checks++;
    if (got8 !== exp8 || sat8 !== es || acc_valid8 !== 1'b1) begin
      errors++; $display("FAIL basic_acc8: got %0d sat %0b valid %0b required %0d sat %0b valid 1", got8, sat8, acc_valid8, exp8, es);
    end
    take_result();
  endtask

  task automatic test_extremes();
    bit ok, es;
    int t0, t1, exp, exp8, got8;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N_TERMS; i++) begin pa[i] = -8; pb[i] = (k == 0) ? -8 : 7; end
      exp = model_sum(N_TERMS);
      send_terms(N_TERMS, t0);
      wait_done(ok, t1);
      checks++;
      if (!ok || int'($signed(acc_o)) !== exp || sat_o !== 1'b0) begin
        errors++; $display("FAIL extreme_sum%0d: got %0d sat %0b required %0d sat 0", k, $signed(acc_o), sat_o, exp);
      end
      exp8 = model_acc8(N_TERMS, es);
      got8 = int'($signed(acc8));
      checks++;
      if (got8 !== exp8 || sat8 !== es) begin
        errors++; $display("FAIL extreme_acc8_%0d: got %0d sat %0b required %0d sat %0b", k, got8, sat8, exp8, es);
      end
      take_result();
    end
  endtask

  task automatic test_hold();
    bit ok, es;
    int t0, t1, exp, exp8;
    for (int i = 0; i < N_TERMS; i++) begin pa[i] = rand_op(); pb[i] = rand_op(); end
    exp = model_sum(N_TERMS);
    exp8 = model_acc8(N_TERMS, es);
    send_terms(N_TERMS, t0);
    wait_done(ok, t1);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (acc_valid_o !== 1'b1 || int'($signed(acc_o)) !== exp || in_ready_o !== 1'b0) begin
        errors++; $display("FAIL hold_c%0d: valid=%0b acc=%0d in_ready=%0b required 1/%0d/0", i, acc_valid_o, $signed(acc_o), in_ready_o, exp);
      end
      @(negedge clk);
    end
    checks++;
    if (int'($signed(acc8)) !== exp8 || sat8 !== es) begin
      errors++; $display("FAIL hold_acc8: got %0d sat %0b required %0d sat %0b", $signed(acc8), sat8, exp8, es);
    end
    take_result();
    checks++;
    if (acc_valid_o !== 1'b0 || acc_o !== '0 || acc8 !== '0 || sat8 !== 1'b0 || in_ready_o !== 1'b1) begin
      errors++; $display("FAIL hold_release: valid=%0b acc=%0d acc8=%0d sat8=%0b in_ready=%0b required 0/0/0/0/1",
                         acc_valid_o, acc_o, acc8, sat8, in_ready_o);
    end
  endtask

  task automatic test_clear();
    bit ok, es;
    int t0, t1, n, exp8;
    for (int i = 0; i < 3; i++) begin pa[i] = rand_op(); pb[i] = rand_op(); end
    send_terms(3, t0);
    n = 0;
    while (!in_ready_o && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (int'($signed(acc_o)) !== model_sum(3) || in_ready_o !== 1'b1) begin
      errors++; $display("FAIL clear_partial: acc=%0d in_ready=%0b required %0d/1", $signed(acc_o), in_ready_o, model_sum(3));
    end
    clear = 1'b1;
    #1;
    checks++;
    if (in_ready_o !== 1'b0) begin errors++; $display("FAIL clear_ready: got %0b required 0", in_ready_o); end
    @(negedge clk);
    clear = 1'b0;
    #1;
    checks++;
    if (acc_o !== '0 || dbg_state_o !== 3'(ST_IDLE) || in_ready_o !== 1'b1) begin
      errors++; $display("FAIL clear_state: acc=%0d state=%0d in_ready=%0b required 0/%0d/1", acc_o, dbg_state_o, in_ready_o, ST_IDLE);
    end
    @(negedge clk);
    for (int i = 0; i < N_TERMS; i++) begin pa[i] = 1; pb[i] = 1; end
    send_terms(N_TERMS, t0);
    wait_done(ok, t1);
    exp8 = model_acc8(N_TERMS, es);
    checks++;
    if (!ok || int'($signed(acc_o)) !== 8 || int'($signed(acc8)) !== exp8) begin
      errors++; $display("FAIL clear_resume: valid=%0b acc=%0d acc8=%0d required 1/8/%0d", ok, $signed(acc_o), $signed(acc8), exp8);
    end
    take_result();
  endtask

  task automatic test_reset_mid_wait();
    bit ok, es;
    int t0, t1, exp, exp8;
    send_pair(5, 5);
    @(negedge clk);
    checks++;
    if (dbg_state_o !== 3'(ST_WAIT)) begin errors++; $display("FAIL midwait_state: got %0d required %0d", dbg_state_o, ST_WAIT); end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (mult_start_o !== 1'b0 || in_ready_o !== 1'b0) begin
        errors++; $display("FAIL midwait_rst_c%0d: start=%0b in_ready=%0b required 0/0", i, mult_start_o, in_ready_o);
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready_o !== 1'b1 || acc_o !== '0 || dbg_state_o !== 3'(ST_IDLE) || mult_start_o !== 1'b0) begin
      errors++; $display("FAIL midwait_release: in_ready=%0b acc=%0d state=%0d start=%0b required 1/0/%0d/0",
                         in_ready_o, acc_o, dbg_state_o, ST_IDLE, mult_start_o);
    end
    @(negedge clk);
    for (int i = 0; i < N_TERMS; i++) begin pa[i] = rand_op(); pb[i] = rand_op(); end
    exp = model_sum(N_TERMS);
    exp8 = model_acc8(N_TERMS, es);
    send_terms(N_TERMS, t0);
    wait_done(ok, t1);
    checks++;
    if (!ok || int'($signed(acc_o)) !== exp || int'($signed(acc8)) !== exp8) begin
      errors++; $display("FAIL midwait_after: valid=%0b acc=%0d acc8=%0d required 1/%0d/%0d", ok, $signed(acc_o), $signed(acc8), exp, exp8);
    end
    take_result();
  endtask

  task automatic test_random();
    bit ok, es;
    int t0, t1, exp, exp8;
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < N_TERMS; i++) begin pa[i] = rand_op(); pb[i] = rand_op(); end
      exp = model_sum(N_TERMS);
      exp8 = model_acc8(N_TERMS, es);
      send_terms(N_TERMS, t0);
      wait_done(ok, t1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      checks++;
      if (!ok || int'($signed(acc_o)) !== exp || sat_o !== 1'b0) begin
        errors++; $display("FAIL random%0d_sum: valid=%0b acc=%0d sat=%0b required 1/%0d/0", r, ok, $signed(acc_o), sat_o, exp);
      end
      checks++;
      if (int'($signed(acc8)) !== exp8 || sat8 !== es) begin
        errors++; $display("FAIL random%0d_acc8: got %0d sat %0b required %0d sat %0b", r, $signed(acc8), sat8, exp8, es);
      end
      take_result();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_extremes();
    test_hold();
    test_clear();
    test_reset_mid_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
